// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Brief    : Single-port data memory with registered read data, a hardware
//            clear sequence after reset, and out-of-range address flagging.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  Rm,
  input  logic                  Wm,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] RegVal,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Data_valid,
  output logic                  busy,
  output logic                  addr_err
);

  // Counter just wide enough to hold DEPTH-1; also the in-range word index width.
  localparam int                    CNT_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0]  LAST_WORD = CNT_WIDTH'(DEPTH - 1);
  // One extra bit so DEPTH = 2^ADDR_WIDTH is representable in the range compare.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;
  localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  logic [0:0]            state;
  logic [CNT_WIDTH-1:0]  clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic [CNT_WIDTH-1:0]  word_idx;
  logic                  rd_go;
  logic                  wr_go;
  logic                  req_go;

  assign busy     = (state == ST_CLEAR);
  assign in_range = ({1'b0, address} < DEPTH_EXT);
  // Only meaningful when in_range; out-of-range accesses are masked below.
  assign word_idx = address[CNT_WIDTH-1:0];

  // Requests are only honoured once the clear sequence has finished.
  assign rd_go  = !busy && Rm;
  assign wr_go  = !busy && Wm && in_range;
  assign req_go = !busy && (Rm || Wm);

  // Clear sequencer: walk every word once, then hand over to normal operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_RESET;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_cnt == LAST_WORD) begin
        state   <= ST_IDLE;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Storage array: no reset so contents survive a reset pulse; held off while
  // reset is asserted so the forced clear pointer cannot scribble on word 0.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (busy) begin
        mem[clr_cnt] <= '0;
      end else if (wr_go) begin
        mem[word_idx] <= RegVal;
      end
    end
  end

  // Registered read port and status pulses; a combined read/write returns the
  // new data, and an out-of-range read returns zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Data_out   <= '0;
      Data_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      Data_valid <= rd_go;
      addr_err   <= req_go && !in_range;
      if (rd_go) begin
        if (!in_range) begin
          Data_out <= '0;
        end else if (Wm) begin
          Data_out <= RegVal;
        end else begin
          Data_out <= mem[word_idx];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctrl
// Brief    : Self-checking bench for data_memory_ctrl. Three instances cover
//            the default build, DEPTH=200 and CLEAR_ON_RESET=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

  logic            clock;
  logic [2:0]      rstn;
  logic [2:0]      rm;
  logic [2:0]      wm;
  logic [2:0][7:0] addr;
  logic [2:0][7:0] wd;
  logic [2:0][7:0] dout;
  logic [2:0]      valid;
  logic [2:0]      bsy;
  logic [2:0]      aerr;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance.
  int       depth_of   [3] = '{256, 200, 256};
  bit       cor        [3] = '{1'b1, 1'b1, 1'b0};
  int       clear_left [3];
  logic [7:0] exp_dout [3];
  logic [7:0] mdl      [3][256];

  data_memory_ctrl u_dut0 (
    .clock(clock), .reset_n(rstn[0]), .Rm(rm[0]), .Wm(wm[0]),
    .address(addr[0]), .RegVal(wd[0]), .Data_out(dout[0]),
    .Data_valid(valid[0]), .busy(bsy[0]), .addr_err(aerr[0]));

  data_memory_ctrl #(.DEPTH(200)) u_dut1 (
    .clock(clock), .reset_n(rstn[1]), .Rm(rm[1]), .Wm(wm[1]),
    .address(addr[1]), .RegVal(wd[1]), .Data_out(dout[1]),
    .Data_valid(valid[1]), .busy(bsy[1]), .addr_err(aerr[1]));

  data_memory_ctrl #(.CLEAR_ON_RESET(1'b0)) u_dut2 (
    .clock(clock), .reset_n(rstn[2]), .Rm(rm[2]), .Wm(wm[2]),
    .address(addr[2]), .RegVal(wd[2]), .Data_out(dout[2]),
    .Data_valid(valid[2]), .busy(bsy[2]), .addr_err(aerr[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold reset low for cyc edges, check the forced outputs, release between edges.
  task automatic do_reset(input int k, input int cyc);
    rstn[k] = 1'b0;
    #1;
    chk($sformatf("rst%0d_dout", k),  dout[k],  0);
    chk($sformatf("rst%0d_valid", k), valid[k], 0);
    chk($sformatf("rst%0d_err", k),   aerr[k],  0);
    chk($sformatf("rst%0d_busy", k),  bsy[k],   cor[k]);
    repeat (cyc) @(posedge clock);
    #1;
    rstn[k]      = 1'b1;
    exp_dout[k]  = 8'h00;
    clear_left[k] = cor[k] ? depth_of[k] : 0;
    if (cor[k]) for (int i = 0; i < 256; i++) mdl[k][i] = 8'h00;
  endtask

  // One clock of traffic on instance k, checked against the model afterwards.
  task automatic step(input int k, input string tag, input bit r, input bit w,
                      input logic [7:0] a, input logic [7:0] d);
    bit ev;
    bit ee;
    bit inr;
    rm[k] = r; wm[k] = w; addr[k] = a; wd[k] = d;
    @(posedge clock);
    #1;
    ev = 1'b0;
    ee = 1'b0;
    if (clear_left[k] > 0) begin
      clear_left[k]--;
    end else if (r || w) begin
      inr = (int'(a) < depth_of[k]);
      ee  = !inr;
      if (r) begin
        ev = 1'b1;
        if (!inr)   exp_dout[k] = 8'h00;
        else if (w) exp_dout[k] = d;
        else        exp_dout[k] = mdl[k][a];
      end
      if (w && inr) mdl[k][a] = d;
    end
    chk($sformatf("%s_busy", tag),  bsy[k],   (clear_left[k] > 0) ? 1 : 0);
    chk($sformatf("%s_valid", tag), valid[k], ev);
    chk($sformatf("%s_err", tag),   aerr[k],  ee);
    chk($sformatf("%s_dout", tag),  dout[k],  exp_dout[k]);
    rm[k] = 1'b0; wm[k] = 1'b0;
  endtask

  initial begin
    int n;
    rstn = '0; rm = '0; wm = '0; addr = '0; wd = '0;
    for (int k = 0; k < 3; k++) begin
      clear_left[k] = 0;
      exp_dout[k]   = 8'h00;
    end

    // ---------------- default instance: clear length and abort ----------------
    do_reset(0, 2);
    for (int i = 0; i < 100; i++) step(0, "clr0", 1'b0, 1'b0, 8'h00, 8'h00);
    do_reset(0, 2);
    step(0, "r35_wr", 1'b0, 1'b1, 8'h33, 8'hFF);
    n = 1;
    while (bsy[0] && n < 1000) begin
      step(0, "r35_clr", 1'b0, 1'b0, 8'h00, 8'h00);
      n++;
    end
    chk("r35_busy_cycles", n, 256);
    step(0, "r35_rd", 1'b1, 1'b0, 8'h33, 8'h00);
    chk("r35_word", dout[0], 8'h00);

    // Read after clear, then the pulse must drop and Data_out hold.
    step(0, "r31_rd", 1'b1, 1'b0, 8'h80, 8'h00);
    chk("r31_valid", valid[0], 1'b1);
    step(0, "r31_idle", 1'b0, 1'b0, 8'h80, 8'h00);
    chk("r31_valid_drop", valid[0], 1'b0);

    step(0, "r32_wr", 1'b0, 1'b1, 8'h10, 8'hA5);
    step(0, "r32_rd", 1'b1, 1'b0, 8'h10, 8'h00);
    chk("r32_data", dout[0], 8'hA5);
    step(0, "r32_idle", 1'b0, 1'b0, 8'h00, 8'h00);

    step(0, "r33_rw", 1'b1, 1'b1, 8'h20, 8'h3C);
    chk("r33_data", dout[0], 8'h3C);
    step(0, "r33_rd", 1'b1, 1'b0, 8'h20, 8'h00);
    chk("r33_data2", dout[0], 8'h3C);

    // Back-to-back reads keep Data_valid asserted.
    step(0, "b2b_a", 1'b1, 1'b0, 8'h10, 8'h00);
    step(0, "b2b_b", 1'b1, 1'b0, 8'h20, 8'h00);
    step(0, "b2b_c", 1'b1, 1'b0, 8'hFF, 8'h00);

    for (int i = 0; i < 400; i++)
      step(0, "rand0", 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));

    // ---------------- DEPTH = 200 instance ----------------
    do_reset(1, 2);
    n = 0;
    while (bsy[1] && n < 1000) begin
      step(1, "clr1", 1'b0, 1'b0, 8'h00, 8'h00);
      n++;
    end
    chk("d200_busy_cycles", n, 200);
    step(1, "r34_pre", 1'b0, 1'b1, 8'h70, 8'h12);
    step(1, "r34_wr", 1'b0, 1'b1, 8'hF0, 8'h77);
    chk("r34_wr_err", aerr[1], 1'b1);
    step(1, "r34_rd", 1'b1, 1'b0, 8'hF0, 8'h00);
    chk("r34_rd_data", dout[1], 8'h00);
    step(1, "r34_alias", 1'b1, 1'b0, 8'h70, 8'h00);
    chk("r34_alias_data", dout[1], 8'h12);
    step(1, "edge199_wr", 1'b0, 1'b1, 8'd199, 8'hC3);
    step(1, "edge199_rd", 1'b1, 1'b0, 8'd199, 8'h00);
    step(1, "edge200_rw", 1'b1, 1'b1, 8'd200, 8'h99);
    for (int i = 0; i < 300; i++)
      step(1, "rand1", 1'($urandom), 1'($urandom), 8'($urandom_range(150, 255)), 8'($urandom));

    // ---------------- CLEAR_ON_RESET = 0 instance ----------------
    do_reset(2, 2);
    step(2, "r36_wr", 1'b0, 1'b1, 8'h01, 8'h5A);
    do_reset(2, 2);
    chk("r36_busy", bsy[2], 1'b0);
    step(2, "r36_rd", 1'b1, 1'b0, 8'h01, 8'h00);
    chk("r36_data", dout[2], 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
